wb_sched: RTL and testbench

Write-back scheduler between the pipeline's W stage and a single-write-port 15-entry register file. Accepts one retiring instruction per handshake and decodes its destinations from icode/rA/rB/cnd. Issues at most one register write per cycle, so popq takes two write cycles and back-pressures the pipeline. Exports a pending-write mask for decode-stage hazard logic.

---
 rtl/wb_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// Write-back scheduler: decodes retiring instructions into at most two register
// writes and issues them one per cycle. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic        in_cnd,
    input  logic [63:0] in_valE,
    input  logic [63:0] in_valM,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [14:0] pending,
    output logic        bad_icode,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2
    } state_t;

    typedef struct packed {
        logic       e_vld;
        logic [3:0] e;
        logic       m_vld;
        logic [3:0] m;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] icode, input logic [3:0] ra,
                                    input logic [3:0] rb, input logic cnd);
        dec_t d;
        d.e   = 4'hF;
        d.m   = 4'hF;
        d.bad = 1'b0;
        case (icode)
            4'h2: begin
                if (cnd) begin
                    d.e = rb;
                end else begin
                    d.e = 4'hF;
                end
            end
            4'h3, 4'h6:       d.e = rb;
            4'h5:             d.m = ra;
            4'h8, 4'h9, 4'hA: d.e = 4'h4;
            4'hB: begin
                d.e = 4'h4;
                d.m = ra;
            end
            4'hC, 4'hD, 4'hE, 4'hF: d.bad = 1'b1;
            default: begin
                d.e = 4'hF;
                d.m = 4'hF;
            end
        endcase
        d.e_vld = (d.e != 4'hF);
        d.m_vld = (d.m != 4'hF);
        return d;
    endfunction

    function automatic logic [14:0] reg_bit(input logic [3:0] r, input logic vld);
        logic [14:0] b;
        if (vld && (r != 4'hF)) begin
            b = 15'd1 << r;
        end else begin
            b = 15'd0;
        end
        return b;
    endfunction

    state_t      state_r, state_s;
    dec_t        dec_s;
    logic        accept_s;
    logic [3:0]  dste_r, dste_s, dstm_r, dstm_s;
    logic        dstm_vld_r, dstm_vld_s;
    logic [63:0] vale_r, vale_s, valm_r, valm_s;
    logic [14:0] pending_r, pending_s, clr_s, set_s;
    logic        rf_we_r, rf_we_s;
    logic [3:0]  rf_waddr_r, rf_waddr_s;
    logic [63:0] rf_wdata_r, rf_wdata_s;
    logic        bad_r;

    assign dec_s    = decode(in_icode, in_rA, in_rB, in_cnd);
    // Only a held M write blocks a new accept; every other state is a final cycle.
    assign in_ready = (state_r == IDLE) || (state_r == WR_M) ||
                      ((state_r == WR_E) && !dstm_vld_r);
    assign accept_s = in_valid && in_ready;

    // Next state, next held instruction and the write to present next cycle.
    always_comb begin
        state_s    = state_r;
        dste_s     = dste_r;
        dstm_s     = dstm_r;
        dstm_vld_s = dstm_vld_r;
        vale_s     = vale_r;
        valm_s     = valm_r;
        rf_we_s    = 1'b0;
        rf_waddr_s = rf_waddr_r;
        rf_wdata_s = rf_wdata_r;
        case (state_r)
            IDLE: state_s = IDLE;
            WR_E: begin
                if (dstm_vld_r) begin
                    state_s = WR_M;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_M:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        if (accept_s) begin
            dste_s     = dec_s.e;
            dstm_s     = dec_s.m;
            dstm_vld_s = dec_s.m_vld;
            vale_s     = in_valE;
            valm_s     = in_valM;
            if (dec_s.e_vld) begin
                state_s = WR_E;
            end else if (dec_s.m_vld) begin
                state_s = WR_M;
            end else begin
                state_s = IDLE;
            end
        end else begin
            dstm_vld_s = dstm_vld_r;
        end
        case (state_s)
            WR_E: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = dste_s;
                rf_wdata_s = vale_s;
            end
            WR_M: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = dstm_s;
                rf_wdata_s = valm_s;
            end
            default: rf_we_s = 1'b0;
        endcase
    end

    // Pending mask: E bit survives its write when the M write targets the same register.
    always_comb begin
        clr_s = 15'd0;
        case (state_r)
            WR_E: begin
                if (dstm_vld_r && (dstm_r == dste_r)) begin
                    clr_s = 15'd0;
                end else begin
                    clr_s = reg_bit(dste_r, 1'b1);
                end
            end
            WR_M:    clr_s = reg_bit(dstm_r, 1'b1);
            default: clr_s = 15'd0;
        endcase
        if (accept_s) begin
            set_s = reg_bit(dec_s.e, dec_s.e_vld) | reg_bit(dec_s.m, dec_s.m_vld);
        end else begin
            set_s = 15'd0;
        end
        pending_s = (pending_r & ~clr_s) | set_s;
    end

    // State, held instruction, write port and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            dste_r     <= 4'hF;
            dstm_r     <= 4'hF;
            dstm_vld_r <= 1'b0;
            vale_r     <= 64'd0;
            valm_r     <= 64'd0;
            pending_r  <= 15'd0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 4'd0;
            rf_wdata_r <= 64'd0;
            bad_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            dste_r     <= dste_s;
            dstm_r     <= dstm_s;
            dstm_vld_r <= dstm_vld_s;
            vale_r     <= vale_s;
            valm_r     <= valm_s;
            pending_r  <= pending_s;
            rf_we_r    <= rf_we_s;
            rf_waddr_r <= rf_waddr_s;
            rf_wdata_r <= rf_wdata_s;
            bad_r      <= accept_s && dec_s.bad;
        end
    end

    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign pending   = pending_r;
    assign bad_icode = bad_r;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_r;

    // Accepted-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign retire_cnt = cnt_r;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: expected writes are queued at accept and
// checked as rf_we pulses appear.
module tb_wb_sched;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode, in_rA, in_rB;
    logic        in_cnd;
    logic [63:0] in_valE, in_valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [14:0] pending;
    logic        bad_icode;
    logic [31:0] retire_cnt;

    int          n_chk;
    int          n_bad;
    int          n_acc;
    logic [67:0] exp_q[$];

    wb_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB), .in_cnd(in_cnd),
        .in_valE(in_valE), .in_valM(in_valM), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pending(pending), .bad_icode(bad_icode),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of which writes an instruction produces, in issue order.
    task automatic push_exp(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            input logic cnd, input logic [63:0] ve, input logic [63:0] vm);
        case (ic)
            4'h2:             if (cnd && rb != 4'hF) exp_q.push_back({rb, ve});
            4'h3, 4'h6:       if (rb != 4'hF) exp_q.push_back({rb, ve});
            4'h5:             if (ra != 4'hF) exp_q.push_back({ra, vm});
            4'h8, 4'h9, 4'hA: exp_q.push_back({4'h4, ve});
            4'hB: begin
                exp_q.push_back({4'h4, ve});
                if (ra != 4'hF) exp_q.push_back({ra, vm});
            end
            default: ;
        endcase
    endtask

    // Present one instruction until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                        output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_icode = ic; in_rA = ra; in_rB = rb;
        in_cnd = cnd; in_valE = ve; in_valM = vm;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(ic, ra, rb, cnd, ve, vm);
                n_acc++;
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every issued write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {60'd0, rf_waddr}, 64'hFFFF);
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                chk("waddr", {60'd0, rf_waddr}, {60'd0, e[67:64]});
                chk("wdata", rf_wdata, e[63:0]);
            end
        end
    end

    initial begin
        int w;
        logic [31:0] c0;
        n_chk = 0; n_bad = 0; n_acc = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_icode = 4'd0; in_rA = 4'hF; in_rB = 4'hF;
        in_cnd = 1'b0; in_valE = 64'd0; in_valM = 64'd0;
        step(2);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_waddr", {60'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_pending", {49'd0, pending}, 64'd0);
        chk("rst_bad", {63'd0, bad_icode}, 64'd0);
        chk("rst_cnt", {32'd0, retire_cnt}, 64'd0);
        rst_n = 1'b1;
        step(1);

        // irmovq rB=2
        send(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'd0, w);
        chk("irm_we", {63'd0, rf_we}, 64'd1);
        chk("irm_pend", {49'd0, pending}, 64'h4);
        step(1);
        chk("irm_pend_clr", {49'd0, pending}, 64'd0);
        chk("irm_we_off", {63'd0, rf_we}, 64'd0);
        chk("irm_hold", rf_wdata, 64'h55);

        // popq rA=3 followed by OPq rB=1
        send(4'hB, 4'h3, 4'hF, 1'b0, 64'h100, 64'hAB, w);
        chk("pop_ready_lo", {63'd0, in_ready}, 64'd0);
        chk("pop_pend", {49'd0, pending}, 64'h18);
        send(4'h6, 4'hF, 4'h1, 1'b0, 64'h33, 64'd0, w);
        chk("opq_waits", w, 64'd1);
        chk("opq_pend", {49'd0, pending}, 64'h2);
        step(1);

        // popq rA=4: same register for both writes
        send(4'hB, 4'h4, 4'hF, 1'b0, 64'h200, 64'h77, w);
        chk("pop4_pend_e", {49'd0, pending}, 64'h10);
        step(1);
        chk("pop4_pend_m", {49'd0, pending}, 64'h10);
        chk("pop4_we_m", {63'd0, rf_we}, 64'd1);
        step(1);
        chk("pop4_pend_clr", {49'd0, pending}, 64'd0);

        // cmovxx not taken, then taken
        c0 = retire_cnt;
        send(4'h2, 4'h0, 4'h5, 1'b0, 64'h8, 64'd0, w);
        chk("cmov0_we", {63'd0, rf_we}, 64'd0);
        chk("cmov0_pend", {49'd0, pending}, 64'd0);
        send(4'h2, 4'h0, 4'h5, 1'b1, 64'h9, 64'd0, w);
        chk("cmov1_pend", {49'd0, pending}, 64'h20);
        chk("cmov_cnt", {32'd0, retire_cnt}, CNT_EN ? {32'd0, c0 + 32'd2} : 64'd0);

        // bad icode, then mrmovq with no destination
        send(4'hE, 4'h1, 4'h1, 1'b1, 64'h1, 64'h2, w);
        chk("bad_pulse", {63'd0, bad_icode}, 64'd1);
        chk("bad_we", {63'd0, rf_we}, 64'd0);
        send(4'h5, 4'hF, 4'hF, 1'b0, 64'h3, 64'h4, w);
        chk("bad_clear", {63'd0, bad_icode}, 64'd0);
        chk("mrm_none_we", {63'd0, rf_we}, 64'd0);
        send(4'h5, 4'h7, 4'hF, 1'b0, 64'h3, 64'hD00D, w);
        step(3);
        chk("drained", exp_q.size(), 64'd0);
        chk("retire_total", {32'd0, retire_cnt}, CNT_EN ? n_acc : 64'd0);

        // reset during popq's WR_E cycle
        send(4'hB, 4'h3, 4'hF, 1'b0, 64'h300, 64'hCC, w);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_we", {63'd0, rf_we}, 64'd0);
        chk("arst_pend", {49'd0, pending}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_we", {63'd0, rf_we}, 64'd0);
        step(3);
        chk("post_rst_cnt", {32'd0, retire_cnt}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
